main_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the 512 x 256-bit block main memory. It lets the instruction cache (read-only refill port) and the data cache (refill and writeback port) share the single memory port. It serialises one block transaction at a time through a three-state FSM and returns read data with a one-cycle acknowledge.

---
 rtl/main_memory_arbiter_if.sv | 44 ++++
 rtl/main_memory_arbiter.sv | 149 ++++++++++++++
 tb/tb_main_memory_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: bundles the instruction port, data port, memory
// port and busy flag of the main memory arbiter.
// slave  = arbiter side, master = requesters/memory side.
interface main_memory_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_readmem;
    logic              mem_writemem;
    logic [DATA_W-1:0] mem_data_write;
    logic [DATA_W-1:0] mem_data_read;
    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_addr, mem_readmem, mem_writemem, mem_data_write,
        input  mem_data_read,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_addr, mem_readmem, mem_writemem, mem_data_write,
        output mem_data_read,
        input  busy
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: shares one block-memory port between the instruction
// cache (read refills) and the data cache (refills and writebacks).
// One transaction at a time through IDLE -> ISSUE -> DONE; the granted port
// gets a one-cycle ack in DONE with the memory's registered read data.
// Optional feature: define MAIN_MEMORY_ARBITER_RR_EN for round-robin tie
// breaking; otherwise the data port wins every tie.
module main_memory_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    main_memory_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic              grant_d_r;   // 1 = data port owns the current transaction
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rd_r;
    logic              wr_r;
    logic              i_ack_r;
    logic              d_ack_r;
    logic              busy_r;

    logic              req_any_s;
    logic              pick_d_s;

`ifdef MAIN_MEMORY_ARBITER_RR_EN
    logic              last_grant_d_r;  // 1 = data port was served last
`endif

    // Choose which port wins when the FSM is idle
    always_comb begin
        req_any_s = bus.i_req | bus.d_req;
`ifdef MAIN_MEMORY_ARBITER_RR_EN
        if (bus.i_req && bus.d_req) begin
            pick_d_s = ~last_grant_d_r;
        end else begin
            pick_d_s = bus.d_req;
        end
`else
        pick_d_s = bus.d_req;
`endif
    end

    // Transaction sequencer: latch request at grant, strobe memory, ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_d_r <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            busy_r    <= 1'b0;
`ifdef MAIN_MEMORY_ARBITER_RR_EN
            last_grant_d_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    if (req_any_s) begin
                        grant_d_r <= pick_d_s;
                        if (pick_d_s) begin
                            addr_r  <= bus.d_addr;
                            we_r    <= bus.d_we;
                            wdata_r <= bus.d_wdata;
                            rd_r    <= ~bus.d_we;
                            wr_r    <= bus.d_we;
                        end else begin
                            // Instruction side is read-only
                            addr_r  <= bus.i_addr;
                            we_r    <= 1'b0;
                            rd_r    <= 1'b1;
                            wr_r    <= 1'b0;
                        end
`ifdef MAIN_MEMORY_ARBITER_RR_EN
                        last_grant_d_r <= pick_d_s;
`endif
                        busy_r  <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Memory samples on this edge; read data is ready in DONE
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    i_ack_r <= ~grant_d_r;
                    d_ack_r <= grant_d_r;
                    busy_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pass memory read data to the acked port only; zero otherwise
    always_comb begin
        if (i_ack_r) begin
            bus.i_rdata = bus.mem_data_read;
        end else begin
            bus.i_rdata = {DATA_W{1'b0}};
        end
        if (d_ack_r && !we_r) begin
            bus.d_rdata = bus.mem_data_read;
        end else begin
            bus.d_rdata = {DATA_W{1'b0}};
        end
    end

    assign bus.i_ack          = i_ack_r;
    assign bus.d_ack          = d_ack_r;
    assign bus.mem_addr       = addr_r;
    assign bus.mem_readmem    = rd_r;
    assign bus.mem_writemem   = wr_r;
    assign bus.mem_data_write = wdata_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter: directed bench for main_memory_arbiter with a
// 512 x 256-bit registered-read memory model behind the memory port.
// Honours MAIN_MEMORY_ARBITER_RR_EN for the tie-breaking expectations.
module tb_main_memory_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    main_memory_arbiter_if bus ();

    main_memory_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model with a back-door preload port
    logic [255:0] mem [0:511];
    logic [255:0] rd_q;
    logic         pre_we = 1'b0;
    logic [8:0]   pre_addr = 9'd0;
    logic [255:0] pre_data = 256'd0;

    // Memory: registered read, write on strobe, preload takes precedence
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_writemem) begin
            mem[bus.mem_addr] <= bus.mem_data_write;
        end
        if (bus.mem_readmem) begin
            rd_q <= mem[bus.mem_addr];
        end
    end

    assign bus.mem_data_read = rd_q;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [255:0] VAL_A = {8{32'hA5A5_0005}};
    localparam logic [255:0] VAL_B = {8{32'hB0B0_01FF}};
    localparam logic [255:0] VAL_C = {8{32'hC0C0_0010}};
    localparam logic [255:0] VAL_E = {8{32'hEEEE_0010}};
    localparam logic [255:0] VAL_F = {8{32'hF0F0_0020}};
    localparam logic [255:0] VAL_G = {8{32'h6060_0021}};
    localparam logic [255:0] VAL_I = {8{32'h1111_0030}};
    localparam logic [255:0] VAL_D = {8{32'hDDDD_0031}};

`ifdef MAIN_MEMORY_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [8:0] addr, input logic [255:0] data);
        @(negedge clk);
        pre_addr = addr;
        pre_data = data;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    initial begin
        int i_at;
        int d_at;
        logic exp_i;
        logic exp_d;

        bus.i_req   = 1'b0;
        bus.i_addr  = 9'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 9'd0;
        bus.d_wdata = 256'd0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_i_ack", {255'd0, bus.i_ack}, 256'd0);
        check_eq("rst_d_ack", {255'd0, bus.d_ack}, 256'd0);
        check_eq("rst_readmem", {255'd0, bus.mem_readmem}, 256'd0);
        check_eq("rst_writemem", {255'd0, bus.mem_writemem}, 256'd0);
        check_eq("rst_busy", {255'd0, bus.busy}, 256'd0);
        check_eq("rst_mem_addr", {247'd0, bus.mem_addr}, 256'd0);
        check_eq("rst_mem_wdata", bus.mem_data_write, 256'd0);
        check_eq("rst_i_rdata", bus.i_rdata, 256'd0);
        check_eq("rst_d_rdata", bus.d_rdata, 256'd0);
        rst = 1'b0;

        preload(9'h005, VAL_A);
        preload(9'h010, VAL_C);
        preload(9'h020, 256'd0);
        preload(9'h021, 256'd0);
        preload(9'h030, VAL_I);
        preload(9'h031, VAL_D);

        // ---------------- instruction read ----------------
        @(negedge clk);                 // cycle N
        bus.i_req  = 1'b1;
        bus.i_addr = 9'h005;
        @(negedge clk);                 // N+1
        check_eq("ird_readmem", {255'd0, bus.mem_readmem}, 256'd1);
        check_eq("ird_mem_addr", {247'd0, bus.mem_addr}, 256'h005);
        check_eq("ird_busy", {255'd0, bus.busy}, 256'd1);
        check_eq("ird_early_ack", {255'd0, bus.i_ack}, 256'd0);
        @(negedge clk);                 // N+2
        check_eq("ird_ack", {255'd0, bus.i_ack}, 256'd1);
        check_eq("ird_rdata", bus.i_rdata, VAL_A);
        check_eq("ird_d_ack", {255'd0, bus.d_ack}, 256'd0);
        check_eq("ird_readmem_off", {255'd0, bus.mem_readmem}, 256'd0);
        bus.i_req = 1'b0;
        @(negedge clk);                 // N+3
        check_eq("ird_idle_busy", {255'd0, bus.busy}, 256'd0);
        check_eq("ird_ack_pulse", {255'd0, bus.i_ack}, 256'd0);
        check_eq("ird_rdata_zero", bus.i_rdata, 256'd0);

        // ---------------- data write then read ----------------
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 9'h1FF;
        bus.d_wdata = VAL_B;
        @(negedge clk);
        check_eq("dwr_writemem", {255'd0, bus.mem_writemem}, 256'd1);
        check_eq("dwr_readmem", {255'd0, bus.mem_readmem}, 256'd0);
        check_eq("dwr_mem_wdata", bus.mem_data_write, VAL_B);
        @(negedge clk);
        check_eq("dwr_ack", {255'd0, bus.d_ack}, 256'd1);
        check_eq("dwr_d_rdata", bus.d_rdata, 256'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        check_eq("dwr_mem_content", mem[9'h1FF], VAL_B);
        bus.d_req = 1'b1;
        bus.d_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("drd_ack", {255'd0, bus.d_ack}, 256'd1);
        check_eq("drd_rdata", bus.d_rdata, VAL_B);
        bus.d_req = 1'b0;
        @(negedge clk);

        // ---------------- simultaneous requests ----------------
        i_at = RR ? 2 : 5;
        d_at = RR ? 5 : 2;
        bus.i_req  = 1'b1;
        bus.i_addr = 9'h030;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 9'h031;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("tie_i_ack_%0d", k), {255'd0, bus.i_ack}, {255'd0, (k == i_at)});
            check_eq($sformatf("tie_d_ack_%0d", k), {255'd0, bus.d_ack}, {255'd0, (k == d_at)});
            if (k == i_at) begin
                check_eq("tie_i_rdata", bus.i_rdata, VAL_I);
                bus.i_req = 1'b0;
            end
            if (k == d_at) begin
                check_eq("tie_d_rdata", bus.d_rdata, VAL_D);
                bus.d_req = 1'b0;
            end
        end
        @(negedge clk);

        // ---------------- continuous contention ----------------
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_i = ((k % 3) == 2) && RR && (((k / 3) % 2) == 0);
            exp_d = ((k % 3) == 2) && !exp_i;
            check_eq($sformatf("fair_i_%0d", k), {255'd0, bus.i_ack}, {255'd0, exp_i});
            check_eq($sformatf("fair_d_%0d", k), {255'd0, bus.d_ack}, {255'd0, exp_d});
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("fair_idle", {255'd0, bus.busy}, 256'd0);

        // ---------------- reset during a write ----------------
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 9'h010;
        bus.d_wdata = VAL_E;
        @(negedge clk);
        check_eq("rstw_writemem_on", {255'd0, bus.mem_writemem}, 256'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rstw_writemem_off", {255'd0, bus.mem_writemem}, 256'd0);
        check_eq("rstw_busy", {255'd0, bus.busy}, 256'd0);
        check_eq("rstw_d_ack", {255'd0, bus.d_ack}, 256'd0);
        check_eq("rstw_mem_addr", {247'd0, bus.mem_addr}, 256'd0);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_no_ack", {255'd0, bus.d_ack}, 256'd0);
        check_eq("rstw_mem_kept", mem[9'h010], VAL_C);
        bus.d_req = 1'b1;
        bus.d_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_readback_ack", {255'd0, bus.d_ack}, 256'd1);
        check_eq("rstw_readback", bus.d_rdata, VAL_C);
        bus.d_req = 1'b0;
        @(negedge clk);

        // ---------------- request changes after grant ----------------
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 9'h020;
        bus.d_wdata = VAL_F;
        @(negedge clk);
        bus.d_addr  = 9'h021;
        bus.d_wdata = VAL_G;
        #1;
        check_eq("stab_mem_addr", {247'd0, bus.mem_addr}, 256'h020);
        check_eq("stab_mem_wdata", bus.mem_data_write, VAL_F);
        @(negedge clk);
        check_eq("stab_ack", {255'd0, bus.d_ack}, 256'd1);
        bus.d_req = 1'b0;
        @(negedge clk);
        check_eq("stab_written", mem[9'h020], VAL_F);
        check_eq("stab_untouched", mem[9'h021], 256'd0);
        check_eq("stab_hold_addr", {247'd0, bus.mem_addr}, 256'h020);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
